// File: rtl/muldiv_pkg.sv
// Shared ALU opcode constants, FSM state type and opcode decode helper
// for the multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] ALUOP_MUL = 3'b010;
    localparam logic [2:0] ALUOP_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } muldiv_state_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == ALUOP_MUL) || (op == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bundle; the execute stage is
// the master, the sequencer is the slave.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
        output start, alu_op, op_a, op_b, flush,
        input  stall, busy, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, alu_op, op_a, op_b, flush,
        output stall, busy, done, result_lo, result_hi, div_by_zero
    );

endinterface

// File: rtl/muldiv_shift_core.sv
// Datapath for one-bit-per-cycle shift-add multiply and restoring divide.
// acc_q is the WIDTH+1 bit accumulator / partial remainder, q_q the multiplier / quotient.
module muldiv_shift_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        mul_sum   = acc_q + (q_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        acc_d     = acc_q;
        q_d       = q_q;
        b_d       = b_q;
        if (load_i) begin
            acc_d = '0;
            q_d   = a_i;
            b_d   = b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Partial remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
                if (div_shift >= {1'b0, b_q}) begin
                    acc_d = div_diff;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {1'b0, mul_sum[WIDTH:1]};
                q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            q_q   <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            b_q   <= b_d;
        end
    end

    assign lo_o = q_q;
    assign hi_o = acc_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer with pipeline stall; define
// MULDIV_SIGNED_EN for two's-complement operands (default build is unsigned).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             dbz_q, dbz_d;
    logic             dbz_flag_q, dbz_flag_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             accept, load, step;
    logic             op_is_div, b_zero;
    logic [WIDTH-1:0] core_a, core_b, core_lo, core_hi;
    logic [WIDTH-1:0] fix_lo, fix_hi;

    assign op_is_div = (bus.alu_op == ALUOP_DIV);
    assign b_zero    = (bus.op_b == '0);
    assign accept    = (state_q == IDLE) && bus.start && !bus.flush && is_muldiv(bus.alu_op);

`ifdef MULDIV_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_lo_q, neg_lo_d;
    logic neg_hi_q, neg_hi_d;

    assign sign_a = bus.op_a[WIDTH-1];
    assign sign_b = bus.op_b[WIDTH-1];

    // Divide-by-zero loads the raw dividend so it can be returned unchanged as the remainder.
    always_comb begin
        core_a   = sign_a ? -bus.op_a : bus.op_a;
        core_b   = sign_b ? -bus.op_b : bus.op_b;
        neg_lo_d = sign_a ^ sign_b;
        neg_hi_d = op_is_div ? sign_a : (sign_a ^ sign_b);
        if (op_is_div && b_zero) begin
            core_a   = bus.op_a;
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
        end
    end

    always_comb begin
        fix_lo = core_lo;
        fix_hi = core_hi;
        if (div_q) begin
            if (neg_lo_q) fix_lo = -core_lo;
            if (neg_hi_q) fix_hi = -core_hi;
        end else if (neg_lo_q) begin
            {fix_hi, fix_lo} = -{core_hi, core_lo};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (accept) begin
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end
`else
    assign core_a = bus.op_a;
    assign core_b = bus.op_b;
    assign fix_lo = core_lo;
    assign fix_hi = core_hi;
`endif

    muldiv_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .step_i  (step),
        .is_div_i(div_q),
        .a_i     (core_a),
        .b_i     (core_b),
        .lo_o    (core_lo),
        .hi_o    (core_hi)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        dbz_d      = dbz_q;
        dbz_flag_d = dbz_flag_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    cnt_d      = CNT_W'(WIDTH);
                    div_d      = op_is_div;
                    dbz_d      = op_is_div && b_zero;
                    dbz_flag_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (dbz_q) begin
                    dbz_flag_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                // Final values are presented combinationally now and held from the next edge on.
                res_lo_d = dbz_q ? '1 : fix_lo;
                res_hi_d = dbz_q ? core_lo : fix_hi;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_flag_q <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            dbz_q      <= dbz_d;
            dbz_flag_q <= dbz_flag_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
        end
    end

    assign bus.stall       = accept || (state_q == BUSY);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.result_lo   = (state_q == DONE) ? res_lo_d : res_lo_q;
    assign bus.result_hi   = (state_q == DONE) ? res_hi_d : res_hi_q;
    assign bus.div_by_zero = dbz_flag_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random
// multiply/divide traffic checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz);
        longint sa, sb, p, q, r;
`ifdef MULDIV_SIGNED_EN
        sa = $signed(a);
        sb = $signed(b);
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        dbz = 1'b0;
        if (op == ALUOP_MUL) begin
            p  = sa * sb;
            lo = p[W-1:0];
            hi = p[2*W-1:W];
        end else if (b == '0) begin
            lo  = '1;
            hi  = a;
            dbz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[W-1:0];
            hi = r[W-1:0];
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.busy && !bus.done) check("stall_while_busy", bus.stall, 1);
                if (bus.done) begin
                    check("stall_low_in_done", bus.stall, 0);
                    check("done_was_expected", 32'(bus.done), (exp_q.size() > 0) ? 1 : 0);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("result_lo", bus.result_lo, e.lo);
                        check("result_hi", bus.result_hi, e.hi);
                        check("div_by_zero", bus.div_by_zero, e.dbz);
                        check("done_cycle", cyc, e.due);
                        last_lo = e.lo;
                        last_hi = e.hi;
                    end
                end
            end
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic fl, output int acc_cyc);
        logic valid;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.alu_op = op;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.flush  = fl;
        valid      = is_muldiv(op) && !fl;
        #1;
        check("stall_in_accept_cycle", bus.stall, valid);
        acc_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("busy_after_start", bus.busy, valid);
        if (valid) check("dbz_cleared_on_accept", bus.div_by_zero, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", bus.busy, 0);
    endtask

    task automatic issue_exp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] lo, input logic [W-1:0] hi, input logic dbz);
        int   acc;
        exp_t e;
        start_op(op, a, b, 1'b0, acc);
        e.lo  = lo;
        e.hi  = hi;
        e.dbz = dbz;
        e.due = acc + (((op == ALUOP_DIV) && (b == '0)) ? 2 : W + 1);
        exp_q.push_back(e);
        wait_idle();
        check("hold_lo_after_done", bus.result_lo, last_lo);
        check("hold_hi_after_done", bus.result_hi, last_hi);
    endtask

    task automatic issue_rand(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] lo, hi;
        logic         dbz;
        model(op, a, b, lo, hi, dbz);
        issue_exp(op, a, b, lo, hi, dbz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           acc;
        logic [2:0]   op;
        logic [W-1:0] a, b;
        exp_t         e;

        bus.start  = 1'b0;
        bus.alu_op = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.flush  = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_stall", bus.stall, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_lo", bus.result_lo, 0);
        check("reset_hi", bus.result_hi, 0);
        check("reset_dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        issue_exp(ALUOP_MUL, 16'd7, 16'd6, 16'h002A, 16'h0000, 1'b0);
`ifdef MULDIV_SIGNED_EN
        issue_exp(ALUOP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
`else
        issue_exp(ALUOP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0);
`endif
        issue_exp(ALUOP_DIV, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0);
        issue_exp(ALUOP_DIV, 16'd5, 16'd0, 16'hFFFF, 16'h0005, 1'b1);
        check("dbz_held_until_accept", bus.div_by_zero, 1);
`ifdef MULDIV_SIGNED_EN
        issue_exp(ALUOP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
`else
        issue_exp(ALUOP_DIV, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0);
`endif

        // Flush at cycle 5 of mul 3*3: no done, results untouched.
        start_op(ALUOP_MUL, 16'd3, 16'd3, 1'b0, acc);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_to_idle", bus.busy, 0);
        check("flush_keeps_lo", bus.result_lo, last_lo);
        check("flush_keeps_hi", bus.result_hi, last_hi);
        repeat (20) @(negedge clk);

        start_op(ALUOP_MUL, 16'd3, 16'd3, 1'b1, acc);
        start_op(3'b000, 16'd3, 16'd3, 1'b0, acc);
        start_op(3'b111, 16'd9, 16'd2, 1'b0, acc);

        // A second start while busy must be dropped.
        start_op(ALUOP_MUL, 16'd9, 16'd9, 1'b0, acc);
        e.lo  = 16'd81;
        e.hi  = 16'd0;
        e.dbz = 1'b0;
        e.due = acc + W + 1;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        bus.start  = 1'b1;
        bus.alu_op = ALUOP_DIV;
        bus.op_a   = 16'd50;
        bus.op_b   = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_start_ignored", bus.busy, 0);

        // Reset in the middle of a divide.
        start_op(ALUOP_DIV, 16'd1000, 16'd3, 1'b0, acc);
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_stall", bus.stall, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        check("rst_mid_lo", bus.result_lo, 0);
        check("rst_mid_hi", bus.result_hi, 0);
        check("rst_mid_dbz", bus.div_by_zero, 0);
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 1) == 0) ? ALUOP_MUL : ALUOP_DIV;
            a  = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = '1;
                default: b = W'($urandom);
            endcase
            issue_rand(op, a, b);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
